// File: rtl/wbu_pkg.sv
// wbu_pkg: shared widths, reset defaults, FSM state encodings and the PC
// increment used by the write-back / commit stage.
package wbu_pkg;

    localparam int              XLEN_DEF     = 32;
    localparam logic [31:0]     RESET_PC_DEF = 32'h8000_0000;
    localparam int              NREGS_DEF    = 32;
    localparam int              REG_IDX_W    = 5;
    localparam int              PC_INC       = 4;

    // Two-state commit FSM: IDLE accepts a packet, HOLD offers the npc to IFU.
    typedef enum logic {
        WBU_IDLE = 1'b0,
        WBU_HOLD = 1'b1
    } wbu_state_e;

endpackage

// File: rtl/wbu_gpr_file.sv
// wbu_gpr_file: architectural GPR array with one synchronous write port and
// two combinational read ports. Index 0 always reads as zero, and a write
// landing in the current cycle is forwarded to a read port asking for it.
module wbu_gpr_file
    import wbu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [XLEN-1:0]      rdata1,
    output logic [XLEN-1:0]      rdata2
);

    logic [XLEN-1:0] regs [NREGS];
    logic            we_nz;

    // Writes to x0 are dropped here so callers need not filter them.
    assign we_nz = we && (waddr != '0);

    // Register array: cleared on reset, one write per cycle otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we_nz) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: x0 forced to zero, same-cycle write forwarded.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (we_nz && (waddr == raddr1)) rdata1 = wdata;
        if (we_nz && (waddr == raddr2)) rdata2 = wdata;
        if (raddr1 == '0)               rdata1 = '0;
        if (raddr2 == '0)               rdata2 = '0;
    end

endmodule

// File: rtl/wbu.sv
// wbu: write-back / commit stage. Retires one packet per accept, writes rd
// into the GPR file it owns, resolves the next PC and offers it to IFU.
// Optional build macro WBU_RETIRE_CNT_EN adds a 64-bit retire counter output
// o_retire_cnt that counts post handshakes.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both high. The upstream side is ready only in IDLE and
// the downstream side is valid only in HOLD, so at most one instruction
// retires every two cycles; while HOLD waits for i_post_ready, o_wbu_npc and
// o_post_valid stay stable and all packet inputs are ignored.
module wbu
    import wbu_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF,
    parameter int               NREGS    = NREGS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_pre_valid,
    output logic                 o_pre_ready,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    input  logic [XLEN-1:0]      i_wbu_pc,
    input  logic [XLEN-1:0]      i_wbu_imm,
    input  logic [XLEN-1:0]      i_wbu_rs1,
    input  logic                 i_wbu_is_jal,
    input  logic                 i_wbu_is_jalr,
    input  logic                 i_wbu_brch,
    input  logic [XLEN-1:0]      i_wbu_rd,
    input  logic [REG_IDX_W-1:0] i_wbu_rd_id,
    input  logic                 i_wbu_gpr_wen,
    input  logic [REG_IDX_W-1:0] i_rs1_id,
    input  logic [REG_IDX_W-1:0] i_rs2_id,
    output logic [XLEN-1:0]      o_rs1,
    output logic [XLEN-1:0]      o_rs2,
    output logic [XLEN-1:0]      o_wbu_npc,
`ifdef WBU_RETIRE_CNT_EN
    output logic [63:0]          o_retire_cnt,
`endif
    output wbu_state_e           o_dbg_state
);

    wbu_state_e      state;
    wbu_state_e      state_next;
    logic            accept;
    logic            post_fire;
    logic [XLEN-1:0] npc_reg;
    logic [XLEN-1:0] npc_next;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= WBU_IDLE;
        else     state <= state_next;
    end

    // FSM next state: IDLE->HOLD on accept, HOLD->IDLE on post handshake.
    always_comb begin
        state_next = state;
        case (state)
            WBU_IDLE: if (i_pre_valid)  state_next = WBU_HOLD;
            WBU_HOLD: if (i_post_ready) state_next = WBU_IDLE;
            default:                    state_next = WBU_IDLE;
        endcase
    end

    // FSM outputs and the two handshake strobes.
    always_comb begin
        o_pre_ready  = (state == WBU_IDLE);
        o_post_valid = (state == WBU_HOLD);
        accept       = i_pre_valid  && o_pre_ready;
        post_fire    = o_post_valid && i_post_ready;
    end

    // Next-PC resolution, priority jalr > jal > branch > sequential.
    always_comb begin
        if (i_wbu_is_jalr) begin
            npc_next = (i_wbu_rs1 + i_wbu_imm) & ~XLEN'(1);
        end else if (i_wbu_is_jal || i_wbu_brch) begin
            npc_next = i_wbu_pc + i_wbu_imm;
        end else begin
            npc_next = i_wbu_pc + XLEN'(PC_INC);
        end
    end

    // Capture the resolved npc only at the accept edge.
    always_ff @(posedge clk) begin
        if (rst)         npc_reg <= RESET_PC;
        else if (accept) npc_reg <= npc_next;
    end

    assign o_wbu_npc   = npc_reg;
    assign o_dbg_state = state;

`ifdef WBU_RETIRE_CNT_EN
    logic [63:0] retire_cnt;

    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (rst)            retire_cnt <= '0;
        else if (post_fire) retire_cnt <= retire_cnt + 64'd1;
    end

    assign o_retire_cnt = retire_cnt;
`else
    logic unused_post_fire;
    assign unused_post_fire = post_fire;
`endif

    wbu_gpr_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_gpr (
        .clk    (clk),
        .rst    (rst),
        .we     (accept && i_wbu_gpr_wen),
        .waddr  (i_wbu_rd_id),
        .wdata  (i_wbu_rd),
        .raddr1 (i_rs1_id),
        .raddr2 (i_rs2_id),
        .rdata1 (o_rs1),
        .rdata2 (o_rs2)
    );

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed bench for the write-back stage. Expected npc values are
// queued when a packet is driven and popped at the post handshake; a small
// GPR model predicts read-port values.
module tb_wbu;
    import wbu_pkg::*;

    localparam int XLEN = 32;

    logic             clk;
    logic             rst;
    logic             i_pre_valid;
    logic             o_pre_ready;
    logic             o_post_valid;
    logic             i_post_ready;
    logic [XLEN-1:0]  i_wbu_pc;
    logic [XLEN-1:0]  i_wbu_imm;
    logic [XLEN-1:0]  i_wbu_rs1;
    logic             i_wbu_is_jal;
    logic             i_wbu_is_jalr;
    logic             i_wbu_brch;
    logic [XLEN-1:0]  i_wbu_rd;
    logic [4:0]       i_wbu_rd_id;
    logic             i_wbu_gpr_wen;
    logic [4:0]       i_rs1_id;
    logic [4:0]       i_rs2_id;
    logic [XLEN-1:0]  o_rs1;
    logic [XLEN-1:0]  o_rs2;
    logic [XLEN-1:0]  o_wbu_npc;
    wbu_state_e       o_dbg_state;
`ifdef WBU_RETIRE_CNT_EN
    logic [63:0]      o_retire_cnt;
`endif

    logic [XLEN-1:0]  exp_q[$];
    logic [XLEN-1:0]  model [32];
    longint unsigned  retire_exp;
    int               test_cnt;
    int               fail_cnt;

    wbu dut (
        .clk           (clk),
        .rst           (rst),
        .i_pre_valid   (i_pre_valid),
        .o_pre_ready   (o_pre_ready),
        .o_post_valid  (o_post_valid),
        .i_post_ready  (i_post_ready),
        .i_wbu_pc      (i_wbu_pc),
        .i_wbu_imm     (i_wbu_imm),
        .i_wbu_rs1     (i_wbu_rs1),
        .i_wbu_is_jal  (i_wbu_is_jal),
        .i_wbu_is_jalr (i_wbu_is_jalr),
        .i_wbu_brch    (i_wbu_brch),
        .i_wbu_rd      (i_wbu_rd),
        .i_wbu_rd_id   (i_wbu_rd_id),
        .i_wbu_gpr_wen (i_wbu_gpr_wen),
        .i_rs1_id      (i_rs1_id),
        .i_rs2_id      (i_rs2_id),
        .o_rs1         (o_rs1),
        .o_rs2         (o_rs2),
        .o_wbu_npc     (o_wbu_npc),
`ifdef WBU_RETIRE_CNT_EN
        .o_retire_cnt  (o_retire_cnt),
`endif
        .o_dbg_state   (o_dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Read a register through port 1 and compare with the model.
    task automatic check_reg(input string tag, input logic [4:0] id);
        i_rs1_id = id;
        #1;
        check(tag, o_rs1, model[id]);
    endtask

    // Drive one packet at a negedge in IDLE; checks the rs2 bypass before the
    // accept edge and o_post_valid after it.
    task automatic send(input string tag, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                        input logic [XLEN-1:0] rs1, input logic jal, input logic jalr,
                        input logic brch, input logic [XLEN-1:0] rd, input logic [4:0] rd_id,
                        input logic wen, input logic [XLEN-1:0] exp_npc);
        logic [XLEN-1:0] exp_rs2;
        check({tag, "_pre_ready"}, 64'(o_pre_ready), 64'd1);
        i_wbu_pc      = pc;
        i_wbu_imm     = imm;
        i_wbu_rs1     = rs1;
        i_wbu_is_jal  = jal;
        i_wbu_is_jalr = jalr;
        i_wbu_brch    = brch;
        i_wbu_rd      = rd;
        i_wbu_rd_id   = rd_id;
        i_wbu_gpr_wen = wen;
        i_rs2_id      = rd_id;
        i_pre_valid   = 1'b1;
        exp_q.push_back(exp_npc);
        exp_rs2 = (wen && rd_id != 5'd0) ? rd : model[rd_id];
        #1;
        check({tag, "_bypass_rs2"}, 64'(o_rs2), 64'(exp_rs2));
        @(negedge clk);
        i_pre_valid = 1'b0;
        if (wen && rd_id != 5'd0) model[rd_id] = rd;
        check({tag, "_post_valid"}, 64'(o_post_valid), 64'd1);
    endtask

    // Complete the post handshake and compare npc against the scoreboard.
    task automatic drain(input string tag);
        int waited;
        logic [XLEN-1:0] exp_npc;
        waited = 0;
        while (!o_post_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_drain_valid"}, 64'(o_post_valid), 64'd1);
        i_post_ready = 1'b1;
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            exp_npc = exp_q.pop_front();
            check({tag, "_npc"}, 64'(o_wbu_npc), 64'(exp_npc));
        end
        retire_exp++;
        @(negedge clk);
        i_post_ready = 1'b0;
        check({tag, "_idle_after"}, 64'(o_pre_ready), 64'd1);
    endtask

    initial begin
        test_cnt      = 0;
        fail_cnt      = 0;
        retire_exp    = 0;
        rst           = 1'b1;
        i_pre_valid   = 1'b0;
        i_post_ready  = 1'b0;
        i_wbu_pc      = '0;
        i_wbu_imm     = '0;
        i_wbu_rs1     = '0;
        i_wbu_is_jal  = 1'b0;
        i_wbu_is_jalr = 1'b0;
        i_wbu_brch    = 1'b0;
        i_wbu_rd      = '0;
        i_wbu_rd_id   = '0;
        i_wbu_gpr_wen = 1'b0;
        i_rs1_id      = '0;
        i_rs2_id      = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check("rst_npc", 64'(o_wbu_npc), 64'h8000_0000);
        check("rst_post_valid", 64'(o_post_valid), 64'd0);
        check("rst_pre_ready", 64'(o_pre_ready), 64'd1);
        check_reg("rst_rs1_id5", 5'd5);
        check("rst_rs1_id5_zero", 64'(o_rs1), 64'd0);
`ifdef WBU_RETIRE_CNT_EN
        check("rst_retire_cnt", o_retire_cnt, 64'd0);
`endif

        // Sequential retire with GPR write.
        send("seq", 32'h8000_0010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
             32'hDEAD_BEEF, 5'd3, 1'b1, 32'h8000_0014);
        check("seq_npc_hold", 64'(o_wbu_npc), 64'h8000_0014);
        check_reg("seq_rd3", 5'd3);
        check("seq_rd3_value", 64'(o_rs1), 64'hDEAD_BEEF);
        drain("seq");

        // jalr wins over jal, bit 0 cleared.
        send("jalr", 32'h8000_0100, 32'h2, 32'h8000_1001, 1'b1, 1'b1, 1'b0,
             32'h0, 5'd0, 1'b0, 32'h8000_1002);
        drain("jalr");

        // jal wins over brch; jal target = pc + imm.
        send("jal", 32'h8000_0200, 32'h40, 32'h1234_5678, 1'b1, 1'b0, 1'b1,
             32'h0000_0055, 5'd12, 1'b1, 32'h8000_0240);
        drain("jal");

        // Taken branch with negative offset.
        send("brch", 32'h0000_0100, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 1'b1,
             32'h0, 5'd1, 1'b0, 32'h0000_00F0);
        drain("brch");

        // Backpressure: packet B held on the input while A waits in HOLD.
        send("bp_a", 32'h8000_0300, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
             32'h0000_1111, 5'd9, 1'b1, 32'h8000_0304);
        i_wbu_pc      = 32'h8000_0400;
        i_wbu_imm     = 32'h0000_0020;
        i_wbu_brch    = 1'b1;
        i_wbu_rd      = 32'h0000_2222;
        i_wbu_rd_id   = 5'd9;
        i_wbu_gpr_wen = 1'b1;
        i_pre_valid   = 1'b1;
        i_rs1_id      = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_npc_stable", 64'(o_wbu_npc), 64'h8000_0304);
            check("bp_pre_ready_low", 64'(o_pre_ready), 64'd0);
            check("bp_post_valid_high", 64'(o_post_valid), 64'd1);
            check("bp_no_second_write", 64'(o_rs1), 64'h0000_1111);
            @(negedge clk);
        end
        i_post_ready = 1'b1;
        #1;
        check("bp_a_npc", 64'(o_wbu_npc), 64'(exp_q.pop_front()));
        retire_exp++;
        @(negedge clk);
        i_post_ready = 1'b0;
        check("bp_idle_after_post", 64'(o_pre_ready), 64'd1);
        exp_q.push_back(32'h8000_0420);
        @(negedge clk);
        i_pre_valid = 1'b0;
        model[9] = 32'h0000_2222;
        check("bp_b_accepted", 64'(o_post_valid), 64'd1);
        check_reg("bp_b_rd9", 5'd9);
        drain("bp_b");

        // x0 write dropped.
        send("x0", 32'h8000_0500, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
             32'h0000_1234, 5'd0, 1'b1, 32'h8000_0504);
        check_reg("x0_read", 5'd0);
        check("x0_read_zero", 64'(o_rs1), 64'd0);
        drain("x0");

        // Bypass of id 7 on rs2 in the accept cycle (checked inside send).
        send("byp7", 32'h8000_0600, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
             32'h0000_A5A5, 5'd7, 1'b1, 32'h8000_0604);
        check_reg("byp7_after", 5'd7);
        drain("byp7");

        // Random sequential packets with random writes.
        for (int i = 0; i < 6; i++) begin
            logic [XLEN-1:0] pc;
            logic [XLEN-1:0] rd;
            logic [4:0]      id;
            pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            rd = $urandom();
            id = 5'($urandom_range(0, 31));
            send("rand", pc, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, rd, id, 1'b1, pc + 32'd4);
            drain("rand");
            check_reg("rand_reg", id);
        end
        check_reg("rand_keep_rd3", 5'd3);

        // PC wrap-around.
        send("wrap", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
             32'h0, 5'd0, 1'b0, 32'h0000_0000);
        drain("wrap");

`ifdef WBU_RETIRE_CNT_EN
        check("retire_cnt_before_rst", o_retire_cnt, retire_exp);
`endif

        // Reset while in HOLD: pending npc discarded, GPRs cleared.
        send("rst_hold", 32'h8000_0700, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
             32'h0000_0077, 5'd4, 1'b1, 32'h8000_0704);
        check("rst_hold_in_hold", 64'(o_post_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        retire_exp = 0;
        check("rst_hold_npc", 64'(o_wbu_npc), 64'h8000_0000);
        check("rst_hold_post_valid", 64'(o_post_valid), 64'd0);
        check("rst_hold_pre_ready", 64'(o_pre_ready), 64'd1);
        check_reg("rst_hold_rd4", 5'd4);
        check_reg("rst_hold_rd3", 5'd3);
`ifdef WBU_RETIRE_CNT_EN
        check("rst_hold_retire_cnt", o_retire_cnt, 64'd0);
`endif

        // Operation resumes after reset.
        send("post_rst", 32'h8000_0800, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
             32'h0000_0099, 5'd4, 1'b1, 32'h8000_0804);
        drain("post_rst");
        check_reg("post_rst_rd4", 5'd4);
`ifdef WBU_RETIRE_CNT_EN
        check("post_rst_retire_cnt", o_retire_cnt, retire_exp);
`endif

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
